prio_encoder_db: RTL and testbench
==================================

PRIO_ENCODER_DB -- requirements
Module: prio_encoder_db

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of request inputs (legal 2..16).
REQ-002 Parameter STABLE, default 3, SHALL set the debounce depth in cycles (legal 0..255).
REQ-003 Parameter LOW_FIRST, default 0, SHALL select the priority order: 0 means the highest set index wins, 1 means the lowest set index wins.
REQ-004 Localparam IW SHALL equal clog2(WIDTH).
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; every register SHALL update on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 en  input  1  output enable; it SHALL NOT be debounced.
REQ-009 sw  input  WIDTH  raw request lines, asynchronous-quality, level-sensitive.
REQ-010 y  output  IW  registered encoded index.
REQ-011 vld  output  1  registered flag: at least one committed request is set and en is high.
REQ-012 chg  output  1  one-cycle pulse, high in the first cycle that y or vld shows a new value.
REQ-013 led  output  IW+2  equals {en_q, vld, y}, where en_q is en registered.

Function
REQ-014 The block SHALL hold a sample register sw_s, a saturating counter cnt of width clog2(STABLE+1) (minimum 1 bit), and a committed register sw_c.
REQ-015 At each edge where sw != sw_s: sw_s <= sw and cnt <= 0.
REQ-016 At each edge where sw == sw_s and cnt < STABLE: cnt <= cnt + 1.
REQ-017 sw_c SHALL load sw at the first edge at which sw has been identical for STABLE+1 consecutive edges, counting that edge; with STABLE=0 it loads at every edge.
REQ-018 Any input pulse shorter than STABLE+1 edges SHALL leave sw_c unchanged.
REQ-019 At every edge: y <= en ? enc(sw_c_next) : 0 and vld <= en & |sw_c_next, where sw_c_next is the value sw_c takes at that same edge.
REQ-020 enc SHALL return the index of the highest set bit when LOW_FIRST=0, or the lowest set bit when LOW_FIRST=1.
REQ-021 enc SHALL return 0 when no bit is set.
REQ-022 en changes SHALL reach y, vld and led on the next edge with no debounce.
REQ-023 Debounce state (sw_s, cnt, sw_c) SHALL keep running while en=0.
REQ-024 A commit and an en change at the same edge SHALL both take effect at that edge.
REQ-025 chg SHALL be registered and high for exactly the one cycle after an edge that changed y or vld; it SHALL be low otherwise, including after a commit that re-encodes to the same y and vld.
REQ-026 cnt SHALL saturate at STABLE and SHALL NOT wrap.

Reset
REQ-027 While rst=1 at an edge, the block SHALL apply: y=0, vld=0, chg=0, led=0, en_q=0, sw_s=0, sw_c=0, cnt=0.
REQ-028 rst SHALL take priority over every other update.
REQ-029 rst asserted mid-debounce SHALL discard the partial count.
REQ-030 After rst is released, the first commit SHALL require STABLE+1 identical edges.

Configuration
REQ-031 With macro PRIO_ENC_SEG_EN defined, the block SHALL add output port seg0 (7 bits, active-low, bit order gfedcba).
REQ-032 seg0 SHALL be registered from y and vld, lagging y by one cycle.
REQ-033 seg0 SHALL show the hex digit of y when vld=1, and 7'h7F (all segments off) when vld=0.
REQ-034 seg0 SHALL reset to 7'h7F.
REQ-035 With PRIO_ENC_SEG_EN undefined, the seg0 port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-036 rst=1 for 2 cycles with random sw and en -> y=0, vld=0, chg=0, led=0 (and seg0=7'h7F if the macro is on).
REQ-037 WIDTH=8, STABLE=3, en=1, sw=8'h2C held -> y=3'd5, vld=1, led=5'b11101 after the 4th edge, not earlier; chg=1 for one cycle.
REQ-038 WIDTH=8, STABLE=3, sw=8'h2C for 2 edges then 8'h00 -> y and vld remain 0 and chg never pulses.
REQ-039 LOW_FIRST=1, WIDTH=8, STABLE=3, sw=8'h2C held -> y=3'd2.
REQ-040 WIDTH=8, STABLE=3, with sw=8'h2C committed, en 1->0 -> next edge y=0, vld=0, chg=1.
REQ-041 Same setup, en 0->1 -> next edge y=5, vld=1 with no debounce wait.
REQ-042 WIDTH=16, STABLE=0, macro on, sw=16'h8000 -> next edge y=4'hF, vld=1; following edge seg0=7'h0E.
REQ-043 WIDTH=16, STABLE=0, macro on, then rst -> seg0=7'h7F.

Source files
------------

// File: rtl/prio_encoder_db_if.sv
// ============================================================================
// Module   : prio_encoder_db_if
// Brief    : Request/encoded-index bundle for prio_encoder_db (seg0 present
//            only when PRIO_ENC_SEG_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prio_encoder_db_if #(
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] sw;
  logic [IW-1:0]    y;
  logic             vld;
  logic             chg;
  logic [IW+1:0]    led;
`ifdef PRIO_ENC_SEG_EN
  logic [6:0]       seg0;

  modport slave  (input  en, sw, output y, vld, chg, led, seg0);
  modport master (output en, sw, input  y, vld, chg, led, seg0);
`else
  modport slave  (input  en, sw, output y, vld, chg, led);
  modport master (output en, sw, input  y, vld, chg, led);
`endif

endinterface

`default_nettype wire

// File: rtl/prio_encoder_db.sv
// ============================================================================
// Module   : prio_encoder_db
// Brief    : Debounced priority encoder; optional 7-segment digit output
//            enabled by macro PRIO_ENC_SEG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_encoder_db #(
  parameter int WIDTH     = 8,
  parameter int STABLE    = 3,
  parameter int LOW_FIRST = 0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  prio_encoder_db_if.slave    bus
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE);
  localparam logic [CW-1:0] CNT_LAST = (STABLE == 0) ? '0 : CW'(STABLE - 1);

  logic [WIDTH-1:0] sw_s_q, sw_s_d;
  logic [WIDTH-1:0] sw_c_q, sw_c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    y_q, y_d;
  logic             vld_q, vld_d;
  logic             chg_q, chg_d;
  logic             en_q;
  logic             commit;

  function automatic logic [IW-1:0] enc(input logic [WIDTH-1:0] v);
    int idx;
    enc = '0;
    // Later hits overwrite earlier ones, so scan toward the winning end.
    for (int i = 0; i < WIDTH; i++) begin
      idx = (LOW_FIRST != 0) ? (WIDTH - 1 - i) : i;
      if (v[idx]) enc = IW'(idx);
    end
  endfunction

  // The edge completing STABLE+1 identical samples is the one seeing cnt at STABLE-1.
  assign commit = (STABLE == 0) ? 1'b1
                                : ((bus.sw == sw_s_q) && (cnt_q == CNT_LAST));

  always_comb begin
    sw_s_d = sw_s_q;
    cnt_d  = cnt_q;
    if (bus.sw != sw_s_q) begin
      sw_s_d = bus.sw;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    sw_c_d = commit ? bus.sw : sw_c_q;
    y_d    = bus.en ? enc(sw_c_d) : '0;
    vld_d  = bus.en & (|sw_c_d);
    chg_d  = (y_d != y_q) | (vld_d != vld_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s_q <= '0;
      sw_c_q <= '0;
      cnt_q  <= '0;
      y_q    <= '0;
      vld_q  <= 1'b0;
      chg_q  <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      sw_s_q <= sw_s_d;
      sw_c_q <= sw_c_d;
      cnt_q  <= cnt_d;
      y_q    <= y_d;
      vld_q  <= vld_d;
      chg_q  <= chg_d;
      en_q   <= bus.en;
    end
  end

  assign bus.y   = y_q;
  assign bus.vld = vld_q;
  assign bus.chg = chg_q;
  assign bus.led = {en_q, vld_q, y_q};

`ifdef PRIO_ENC_SEG_EN
  logic [6:0] seg_q, seg_d;

  // Active-low gfedcba hex glyphs.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    seg_d = vld_q ? seg7(4'(y_q)) : 7'h7F;
  end

  always_ff @(posedge clk) begin
    if (rst) seg_q <= 7'h7F;
    else     seg_q <= seg_d;
  end

  assign bus.seg0 = seg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prio_encoder_db.sv
// ============================================================================
// Module   : tb_prio_encoder_db
// Brief    : Self-checking bench for prio_encoder_db (three configurations).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_encoder_db;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_drv;
  logic [15:0] sw_drv;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  prio_encoder_db_if #(.WIDTH(8))  bus0 ();
  prio_encoder_db_if #(.WIDTH(8))  bus1 ();
  prio_encoder_db_if #(.WIDTH(16)) bus2 ();

  assign bus0.en = en_drv;
  assign bus0.sw = sw_drv[7:0];
  assign bus1.en = en_drv;
  assign bus1.sw = sw_drv[7:0];
  assign bus2.en = en_drv;
  assign bus2.sw = sw_drv;

  prio_encoder_db #(.WIDTH(8),  .STABLE(3), .LOW_FIRST(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  prio_encoder_db #(.WIDTH(8),  .STABLE(3), .LOW_FIRST(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  prio_encoder_db #(.WIDTH(16), .STABLE(0), .LOW_FIRST(0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference model: run-length of identical samples per instance.
  int          W  [3] = '{8, 8, 16};
  int          ST [3] = '{3, 3, 0};
  int          LF [3] = '{0, 1, 0};
  int          m_run [3];
  logic [15:0] m_last[3];
  logic [15:0] m_com [3];
  int          m_y   [3];
  bit          m_vld [3];
  bit          m_chg [3];
  logic [6:0]  m_seg [3];
  bit          m_enq;
  logic [6:0]  SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int enc_ref(input logic [15:0] v, input int w, input int low);
    if (low != 0) begin
      for (int i = 0; i < w; i++) if (v[i]) return i;
    end else begin
      for (int i = w - 1; i >= 0; i--) if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_edge();
    logic [15:0] s;
    int          ny;
    bit          nv;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_run[k] = 0; m_last[k] = '0; m_com[k] = '0;
        m_y[k] = 0; m_vld[k] = 0; m_chg[k] = 0; m_seg[k] = 7'h7F;
      end else begin
        s = (W[k] == 16) ? sw_drv : (sw_drv & 16'h00FF);
        if (s == m_last[k]) m_run[k]++;
        else begin
          m_last[k] = s;
          m_run[k]  = 1;
        end
        if (ST[k] == 0 || m_run[k] == ST[k] + 1) m_com[k] = s;
        ny = en_drv ? enc_ref(m_com[k], W[k], LF[k]) : 0;
        nv = en_drv && (m_com[k] != 0);
        m_seg[k] = m_vld[k] ? ~SEG_ON[m_y[k]] : 7'h7F;
        m_chg[k] = (ny != m_y[k]) || (nv != m_vld[k]);
        m_y[k]   = ny;
        m_vld[k] = nv;
      end
    end
    m_enq = rst ? 1'b0 : en_drv;
  endtask

  task automatic compare_all();
    check("d0.y",   bus0.y,   m_y[0]);
    check("d0.vld", bus0.vld, m_vld[0]);
    check("d0.chg", bus0.chg, m_chg[0]);
    check("d0.led", bus0.led, {m_enq, m_vld[0], 3'(m_y[0])});
    check("d1.y",   bus1.y,   m_y[1]);
    check("d1.vld", bus1.vld, m_vld[1]);
    check("d1.chg", bus1.chg, m_chg[1]);
    check("d1.led", bus1.led, {m_enq, m_vld[1], 3'(m_y[1])});
    check("d2.y",   bus2.y,   m_y[2]);
    check("d2.vld", bus2.vld, m_vld[2]);
    check("d2.chg", bus2.chg, m_chg[2]);
    check("d2.led", bus2.led, {m_enq, m_vld[2], 4'(m_y[2])});
`ifdef PRIO_ENC_SEG_EN
    check("d0.seg", bus0.seg0, m_seg[0]);
    check("d1.seg", bus1.seg0, m_seg[1]);
    check("d2.seg", bus2.seg0, m_seg[2]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst    = 1'b1;
    en_drv = 1'($urandom);
    sw_drv = 16'($urandom);
    step();
    step();
    check("rst.y",   bus0.y,   0);
    check("rst.vld", bus0.vld, 0);
    check("rst.chg", bus0.chg, 0);
    check("rst.led", bus0.led, 0);
`ifdef PRIO_ENC_SEG_EN
    check("rst.seg", bus2.seg0, 7'h7F);
`endif

    // Held request commits on the 4th edge, not before.
    rst    = 1'b0;
    en_drv = 1'b1;
    sw_drv = 16'h002C;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold.early_vld", bus0.vld, 0);
    end
    step();
    check("hold.y",     bus0.y,   5);
    check("hold.vld",   bus0.vld, 1);
    check("hold.led",   bus0.led, 5'b11101);
    check("hold.chg",   bus0.chg, 1);
    check("low1st.y",   bus1.y,   2);
    step();
    check("hold.chg_drop", bus0.chg, 0);

    en_drv = 1'b0;
    step();
    check("en_off.y",   bus0.y,   0);
    check("en_off.vld", bus0.vld, 0);
    check("en_off.chg", bus0.chg, 1);
    en_drv = 1'b1;
    step();
    check("en_on.y",    bus0.y,   5);
    check("en_on.vld",  bus0.vld, 1);

    // Short pulse is rejected.
    rst = 1'b1;
    step();
    rst    = 1'b0;
    sw_drv = 16'h002C;
    step();
    step();
    sw_drv = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      step();
      check("glitch.vld", bus0.vld, 0);
      check("glitch.chg", bus0.chg, 0);
    end

    // STABLE=0 instance commits immediately.
    sw_drv = 16'h8000;
    step();
    check("s0.y",   bus2.y,   4'hF);
    check("s0.vld", bus2.vld, 1);
    step();
`ifdef PRIO_ENC_SEG_EN
    check("s0.seg", bus2.seg0, 7'h0E);
    rst = 1'b1;
    step();
    check("s0.seg_rst", bus2.seg0, 7'h7F);
    rst = 1'b0;
`endif

    repeat (300) begin
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) en_drv = ~en_drv;
      case ($urandom_range(0, 3))
        0:       sw_drv = sw_drv;
        1:       sw_drv = sw_drv ^ (16'h1 << $urandom_range(0, 15));
        default: sw_drv = 16'($urandom) & 16'($urandom);
      endcase
      repeat ($urandom_range(1, 6)) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
